// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: IF/ID stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush performance counters.
`timescale 1ns/1ps
module pipe_stage_skid #(
   parameter int INSTR_W = 32,
   parameter int PC_W = 32,
   parameter logic [INSTR_W-1:0] BUBBLE_INSTR = {INSTR_W{1'b1}}
`ifdef PIPE_STAGE_PERF_EN
   ,parameter int CNT_W = 16
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   input  logic               flush,
`ifdef PIPE_STAGE_PERF_EN
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`else
   output logic [1:0]         occupancy
`endif
);
   logic               main_valid, skid_valid, accept, consume;
   logic [INSTR_W-1:0] main_instr, skid_instr;
   logic [PC_W-1:0]    main_pc, skid_pc;
   // in_ready depends only on registered skid state (plus the flush override)
   assign in_ready  = flush | ~skid_valid;
   assign out_valid = main_valid & ~flush;
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;
   assign out_instr = out_valid ? main_instr : BUBBLE_INSTR;
   assign out_pc    = out_valid ? main_pc : '0;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_instr <= '0;
         main_pc    <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || consume) begin
         if (skid_valid) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            main_valid <= accept;
            if (accept) begin
               main_instr <= in_instr;
               main_pc    <= in_pc;
            end
         end
      end else if (accept) begin
         skid_instr <= in_instr;
         skid_pc    <= in_pc;
         skid_valid <= 1'b1;
      end
   end
`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised front-end pipeline stage register: the next-generation IF/ID boundary with configurable widths, a valid/ready handshake and a 2-entry skid buffer.
- Upstream (fetch) sees full-throughput acceptance even when the downstream ready is registered.
- Flush kills all held entries and presents a bubble.
- Sits between the fetch unit and the decode unit.
- Any later front-end boundary that needs back-pressure reuses this block.

Parameters:
INSTR_W, 32, instruction payload width
PC_W, 32, PC+4 payload width
BUBBLE_INSTR, {INSTR_W{1'b1}}, instruction value driven whenever no valid entry is presented
CNT_W, 16, width of performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream holds valid instr/pc
in_ready  output  1  stage can accept this cycle
in_instr  input  INSTR_W  fetched instruction
in_pc  input  PC_W  PC+4 of fetched instruction
out_valid  output  1  out_instr/out_pc valid
out_ready  input  1  downstream consumes this cycle (0 = stall)
out_instr  output  INSTR_W  instruction to decode
out_pc  output  PC_W  PC+4 to decode
flush  input  1  synchronous kill of all entries (branch/jump redirect)
occupancy  output  2  number of held entries, 0..2
stall_cnt  output  CNT_W  PIPE_STAGE_PERF_EN only
flush_cnt  output  CNT_W  PIPE_STAGE_PERF_EN only

Behaviour:
- Reset (rst=0, asynchronous): both entries are invalid and payload registers are 0. Outputs are out_valid=0, out_instr=BUBBLE_INSTR, out_pc=0, in_ready=1 and occupancy=0. Counters are 0.
- Storage: a main register (drives outputs) and a skid register, each with its own valid bit.
- in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle).
- Per-edge update when flush=0:
  - Main empty, accept: the input goes to main.
  - Main full, consume, skid empty: main loads the input if accepting, otherwise it goes empty.
  - Main full, consume, skid full: skid moves to main and skid goes empty. No accept is possible because in_ready=0.
  - Main full, no consume, accept: the input goes to skid, so in_ready=0 next cycle.
  - Main full, no consume, no accept: hold.
- Order is strictly FIFO. No entry is ever dropped or duplicated without a flush.
- Output mux: when out_valid=0, out_instr=BUBBLE_INSTR and out_pc=0. Otherwise outputs are the main register contents.
- Flush (sampled at edge):
  - Both valid bits clear at that edge, and the input presented that cycle is discarded even if accepted.
  - During the flush cycle, out_valid is forced to 0 and out_instr/out_pc are forced to bubble combinationally.
  - in_ready is forced to 1 during the flush cycle.
- Flush with out_ready=1 in the same cycle: no consume occurs, because out_valid is forced to 0.
- Flush has priority over stall.
- Payload registers need not clear on flush; only the valid bits are cleared.
- occupancy = main_valid + skid_valid (registered state, not affected by the combinational flush mask).
- Reset mid-operation: immediate return to reset state regardless of clk.

Optional Feature:
PIPE_STAGE_PERF_EN:
- Defined: stall_cnt increments each cycle with out_valid=1 & out_ready=0 & flush=0. flush_cnt increments each cycle with flush=1. Both saturate at all-ones and reset to 0 on rst.
- Undefined: the counters and their ports do not exist, and no extra logic is generated.

Test Plan:
- Reset: rst=0 with in_valid=1 -> out_valid=0, out_instr=32'hFFFFFFFF, out_pc=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, push instrs 0x00000013, 0x00100093, 0x00200113 with pc 4, 8, 12 on back-to-back cycles -> each appears one cycle later in order; in_ready stays 1; occupancy<=1.
- Stall/skid:
  - Push A=0xAAAA0001 and B=0xBBBB0002 with out_ready=0 -> after 2 edges occupancy=2, in_ready=0, out_instr=A.
  - Then out_ready=1 -> A consumed, B next cycle, in_ready returns to 1.
- Flush with full buffer: occupancy=2, then flush=1 with in_valid=1 and in_instr=0xCCCC0003 -> same cycle out_valid=0, out_instr=0xFFFFFFFF, out_pc=0. Next cycle occupancy=0 and C is not presented.
- Simultaneous consume+accept: main holds X=0x11111111, out_ready=1, in_valid=1 with Y=0x22222222 -> next cycle out_instr=Y, occupancy=1.
- Perf (PIPE_STAGE_PERF_EN defined): 5 stall cycles plus 2 flush cycles -> stall_cnt=5, flush_cnt=2. With CNT_W=2, 5 stalls -> stall_cnt=3 (saturated).
